load_use_scoreboard: RTL and testbench



---
 rtl/load_use_if.sv | 31 +++
 rtl/load_use_scoreboard.sv | 112 +++++++++++
 tb/tb_load_use_scoreboard.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_use_if.sv
// load_use_if
//   Decode-stage bundle between the ID stage and the load-use scoreboard.
//   master: decode stage; drives instruction fields, hold and flush, and
//           receives stall and the per-operand hazard flags.
//   slave : scoreboard; the mirror image.
//   Signals: id_valid, opcode[6:0], rd_addr/rs1_addr/rs2_addr[REG_AW-1:0],
//            hold, flush (to scoreboard); stall, haz_rs1, haz_rs2 (from it).
interface load_use_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [6:0]        opcode;
  logic [REG_AW-1:0] rd_addr;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic              hold;
  logic              flush;
  logic              stall;
  logic              haz_rs1;
  logic              haz_rs2;

  modport master (
    output id_valid, opcode, rd_addr, rs1_addr, rs2_addr, hold, flush,
    input  stall, haz_rs1, haz_rs2
  );

  modport slave (
    input  id_valid, opcode, rd_addr, rs1_addr, rs2_addr, hold, flush,
    output stall, haz_rs1, haz_rs2
  );
endinterface

// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard
//   Load-use hazard detector for the RV32I decode stage. Every issued load
//   enters a LOAD_LATENCY-deep age pipeline (entry k = issued k+1 cycles ago);
//   decode stalls while a source register it actually reads matches a valid
//   entry. x0 never hazards. hold freezes the age pipeline, flush kills the
//   decode instruction (no stall, no issue).
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset, clears all entries
//   bus       load_use_if.slave (decode fields in; stall/haz_rs1/haz_rs2 out)
//   stall_cnt [31:0] stall cycles outside hold, only with
//             LOAD_USE_SCOREBOARD_PERF_EN defined
// Parameters
//   REG_AW        register address width (must match the interface)
//   LOAD_LATENCY  1..4 cycles a loaded rd stays unavailable
module load_use_scoreboard #(
  parameter int REG_AW       = 5,
  parameter int LOAD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  load_use_if.slave   bus
`ifdef LOAD_USE_SCOREBOARD_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [LOAD_LATENCY-1:0]             ent_v;
  logic [LOAD_LATENCY-1:0][REG_AW-1:0] ent_rd;

  logic uses_rs1;
  logic uses_rs2;
  logic hit_rs1;
  logic hit_rs2;
  logic haz_rs1_w;
  logic haz_rs2_w;
  logic stall_w;
  logic issue;

  // LUI/AUIPC/JAL and anything unrecognised read no source register.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (bus.opcode)
      OPC_OP, OPC_STORE, OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    for (int k = 0; k < LOAD_LATENCY; k++) begin
      if (ent_v[k] && (ent_rd[k] == bus.rs1_addr)) hit_rs1 = 1'b1;
      if (ent_v[k] && (ent_rd[k] == bus.rs2_addr)) hit_rs2 = 1'b1;
    end
  end

  assign haz_rs1_w = bus.id_valid & uses_rs1 & (bus.rs1_addr != '0) & hit_rs1;
  assign haz_rs2_w = bus.id_valid & uses_rs2 & (bus.rs2_addr != '0) & hit_rs2;

  // Flush dominates: a killed instruction must not hold up the front end.
  assign stall_w = (haz_rs1_w | haz_rs2_w) & ~bus.flush;

  // Loads to x0 produce nothing a consumer could wait on, so they are not tracked.
  assign issue = bus.id_valid & ~stall_w & ~bus.flush &
                 (bus.opcode == OPC_LOAD) & (bus.rd_addr != '0);

  assign bus.stall   = stall_w;
  assign bus.haz_rs1 = haz_rs1_w;
  assign bus.haz_rs2 = haz_rs2_w;

  // Age pipeline: the oldest entry falls off the top; stalled or flushed
  // cycles shift in a bubble because issue is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v  <= '0;
      ent_rd <= '0;
    end else if (!bus.hold) begin
      for (int k = LOAD_LATENCY - 1; k > 0; k--) begin
        ent_v[k]  <= ent_v[k-1];
        ent_rd[k] <= ent_rd[k-1];
      end
      ent_v[0]  <= issue;
      ent_rd[0] <= bus.rd_addr;
    end
  end

`ifdef LOAD_USE_SCOREBOARD_PERF_EN
  // Cycles frozen by hold are attributed to the memory wait, not to load-use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_w && !bus.hold) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
module tb_load_use_scoreboard;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] JAL = 7'b1101111;

  typedef struct {
    logic       v;
    logic [6:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       hold;
    logic       flush;
    logic [2:0] exp;   // {stall, haz_rs1, haz_rs2}
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs[$];

  load_use_if #(.REG_AW(5)) if1 ();
  load_use_if #(.REG_AW(5)) if2 ();
  load_use_if #(.REG_AW(5)) if3 ();

`ifdef LOAD_USE_SCOREBOARD_PERF_EN
  logic [31:0] cnt1, cnt2, cnt3;
  load_use_scoreboard #(.REG_AW(5), .LOAD_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .stall_cnt(cnt1));
  load_use_scoreboard #(.REG_AW(5), .LOAD_LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .stall_cnt(cnt2));
  load_use_scoreboard #(.REG_AW(5), .LOAD_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3), .stall_cnt(cnt3));
`else
  load_use_scoreboard #(.REG_AW(5), .LOAD_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  load_use_scoreboard #(.REG_AW(5), .LOAD_LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  load_use_scoreboard #(.REG_AW(5), .LOAD_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic hold, input logic flush);
    if1.id_valid = v; if1.opcode = op; if1.rd_addr = rd; if1.rs1_addr = rs1;
    if1.rs2_addr = rs2; if1.hold = hold; if1.flush = flush;
    if2.id_valid = v; if2.opcode = op; if2.rd_addr = rd; if2.rs1_addr = rs1;
    if2.rs2_addr = rs2; if2.hold = hold; if2.flush = flush;
    if3.id_valid = v; if3.opcode = op; if3.rd_addr = rd; if3.rs1_addr = rs1;
    if3.rs2_addr = rs2; if3.hold = hold; if3.flush = flush;
  endtask

  task automatic check(input int idx, input string name, input logic [2:0] exp);
    logic [2:0] act;
    case (idx)
      0:       act = {if1.stall, if1.haz_rs1, if1.haz_rs2};
      1:       act = {if2.stall, if2.haz_rs1, if2.haz_rs2};
      default: act = {if3.stall, if3.haz_rs1, if3.haz_rs2};
    endcase
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: stall/haz_rs1/haz_rs2 got %b want %b", name, act, exp);
    end
  endtask

  // One decode cycle: inputs change after the falling edge, outputs sampled 1ns later.
  task automatic step(input int idx, input string name, input logic v, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic hold, input logic flush, input logic [2:0] exp);
    @(negedge clk);
    drive(v, op, rd, rs1, rs2, hold, flush);
    #1;
    check(idx, name, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_vec(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic hold, input logic flush, input logic [2:0] exp);
    vec_t t;
    t.v = v; t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.hold = hold; t.flush = flush; t.exp = exp;
    vecs.push_back(t);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // LOAD_LATENCY=1 table
    add_vec(0, OP,  0, 0, 0, 0, 0, 3'b000);  // idle after reset
    add_vec(1, LD,  5, 1, 0, 0, 0, 3'b000);  // lw x5
    add_vec(1, OP,  6, 5, 7, 0, 0, 3'b110);  // add x6,x5,x7 stalls once
    add_vec(1, OP,  6, 5, 7, 0, 0, 3'b000);  // then issues
    add_vec(0, OP,  0, 0, 0, 0, 0, 3'b000);
    add_vec(1, LD,  5, 2, 0, 0, 0, 3'b000);  // lw x5
    add_vec(1, LUI, 5, 5, 5, 0, 0, 3'b000);  // lui reads nothing
    add_vec(1, LD,  5, 2, 0, 0, 0, 3'b000);  // lw x5
    add_vec(1, JAL, 1, 5, 5, 0, 0, 3'b000);  // jal reads nothing
    add_vec(1, OP,  1, 5, 5, 0, 0, 3'b000);  // entry already gone
    add_vec(1, LD,  0, 3, 0, 0, 0, 3'b000);  // lw x0 not tracked
    add_vec(1, OP,  1, 0, 0, 0, 0, 3'b000);  // add x1,x0,x0
    add_vec(1, LD,  9, 3, 0, 0, 0, 3'b000);  // lw x9
    add_vec(1, ST,  0, 2, 9, 0, 0, 3'b101);  // sw x9 -> rs2 hazard
    add_vec(1, ST,  0, 2, 9, 0, 0, 3'b000);
    add_vec(1, LD,  7, 1, 0, 0, 0, 3'b000);  // lw x7
    add_vec(1, OP,  1, 7, 0, 0, 1, 3'b010);  // hazard + flush -> no stall
    add_vec(1, OP,  1, 7, 0, 0, 0, 3'b000);
    add_vec(1, LD,  7, 1, 0, 0, 1, 3'b000);  // flushed load must not enter
    add_vec(1, OP,  1, 7, 0, 0, 0, 3'b000);
    add_vec(1, LD,  3, 1, 0, 0, 0, 3'b000);  // lw x3
    add_vec(1, LD,  4, 3, 0, 0, 0, 3'b110);  // lw x4,0(x3) load-load dep
    add_vec(1, LD,  4, 3, 0, 0, 0, 3'b000);  // issues now
    add_vec(1, OP,  1, 4, 4, 0, 0, 3'b111);  // both operands hit
    add_vec(1, OP,  1, 4, 4, 0, 0, 3'b000);
    add_vec(1, LD, 10, 1, 0, 0, 0, 3'b000);  // lw x10
    add_vec(1, BR,  0, 11, 10, 0, 0, 3'b101); // beq x11,x10
    add_vec(1, BR,  0, 11, 10, 0, 0, 3'b000);
    add_vec(1, LD, 12, 1, 0, 0, 0, 3'b000);  // lw x12
    add_vec(1, JLR, 1, 12, 12, 0, 0, 3'b110); // jalr ignores rs2
    add_vec(1, JLR, 1, 12, 12, 0, 0, 3'b000);
    add_vec(1, LD, 13, 1, 0, 0, 0, 3'b000);  // lw x13
    add_vec(0, OP,  1, 13, 13, 0, 0, 3'b000); // invalid decode never hazards
    add_vec(1, OP,  1, 13, 13, 0, 0, 3'b000); // entry aged out
    add_vec(1, LD, 14, 1, 0, 0, 0, 3'b000);  // lw x14
    add_vec(1, OPI, 1, 14, 0, 1, 0, 3'b110); // held: entry frozen
    add_vec(1, OPI, 1, 14, 0, 0, 0, 3'b110); // still pending
    add_vec(1, OPI, 1, 14, 0, 0, 0, 3'b000);

    #1;
    check(0, "reset_l1", 3'b000);
    check(1, "reset_l2", 3'b000);
    check(2, "reset_l3", 3'b000);
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
            vecs[i].hold, vecs[i].flush);
      #1;
      check(0, $sformatf("l1_vec%0d", i), vecs[i].exp);
    end

    // L=3: lw x8, then sw x9,0(x8) stalls three cycles on rs2
    do_reset();
    step(2, "l3_lw",  1, LD, 8, 1, 0, 0, 0, 3'b000);
    step(2, "l3_sw1", 1, ST, 0, 9, 8, 0, 0, 3'b101);
    step(2, "l3_sw2", 1, ST, 0, 9, 8, 0, 0, 3'b101);
    step(2, "l3_sw3", 1, ST, 0, 9, 8, 0, 0, 3'b101);
    step(2, "l3_sw4", 1, ST, 0, 9, 8, 0, 0, 3'b000);

    // L=3: back-to-back loads to the same rd, stall until both have aged out
    step(2, "l3_b2b_a", 1, LD, 5, 1, 0, 0, 0, 3'b000);
    step(2, "l3_b2b_b", 1, LD, 5, 1, 0, 0, 0, 3'b000);
    step(2, "l3_b2b_1", 1, OP, 6, 5, 0, 0, 0, 3'b110);
    step(2, "l3_b2b_2", 1, OP, 6, 5, 0, 0, 0, 3'b110);
    step(2, "l3_b2b_3", 1, OP, 6, 5, 0, 0, 0, 3'b110);
    step(2, "l3_b2b_4", 1, OP, 6, 5, 0, 0, 0, 3'b000);

    // L=3: asynchronous reset while a hazard is pending
    step(2, "l3_rst_lw",  1, LD, 8, 1, 0, 0, 0, 3'b000);
    step(2, "l3_rst_pre", 1, OP, 1, 8, 0, 0, 0, 3'b110);
    rst_n = 1'b0;
    #1;
    check(2, "l3_rst_async", 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    step(2, "l3_rst_post", 1, OP, 1, 8, 0, 0, 0, 3'b000);

    // L=2: x0 loads ignored; hold stretches the stall
    do_reset();
    step(1, "l2_lw_x0",  1, LD, 0, 0, 0, 0, 0, 3'b000);
    step(1, "l2_add_x0", 1, OP, 1, 0, 0, 0, 0, 3'b000);
    step(1, "l2_lw_x4",  1, LD, 4, 1, 0, 0, 0, 3'b000);
    step(1, "l2_hold1",  1, OP, 1, 4, 0, 1, 0, 3'b110);
    step(1, "l2_hold2",  1, OP, 1, 4, 0, 1, 0, 3'b110);
    step(1, "l2_run1",   1, OP, 1, 4, 0, 0, 0, 3'b110);
    step(1, "l2_run2",   1, OP, 1, 4, 0, 0, 0, 3'b110);
    step(1, "l2_clear",  1, OP, 1, 4, 0, 0, 0, 3'b000);

`ifdef LOAD_USE_SCOREBOARD_PERF_EN
    // L=1: five stall cycles, one of them under hold -> counter reads 4
    do_reset();
    step(0, "pf_lw5",  1, LD, 5, 1, 0, 0, 0, 3'b000);
    step(0, "pf_s1h",  1, OP, 1, 5, 0, 1, 0, 3'b110);
    step(0, "pf_s2",   1, OP, 1, 5, 0, 0, 0, 3'b110);
    step(0, "pf_ok1",  1, LD, 6, 1, 0, 0, 0, 3'b000);
    step(0, "pf_s3",   1, OP, 1, 6, 0, 0, 0, 3'b110);
    step(0, "pf_ok2",  1, LD, 7, 1, 0, 0, 0, 3'b000);
    step(0, "pf_s4",   1, OP, 1, 7, 0, 0, 0, 3'b110);
    step(0, "pf_ok3",  1, LD, 8, 1, 0, 0, 0, 3'b000);
    step(0, "pf_s5",   1, OP, 1, 8, 0, 0, 0, 3'b110);
    step(0, "pf_idle", 0, OP, 0, 0, 0, 0, 0, 3'b000);
    total++;
    if (cnt1 !== 32'd4) begin
      bad++;
      $display("FAIL stall_cnt: got %0d want 4", cnt1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
